// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: widths, ALU opcodes and the memory/writeback control bundle.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd11;

  // Bits that can cause an architectural side effect; all zero in a NOP.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_event_counter.sv
// Saturating event counter with enable; holds at all-ones instead of wrapping.
module pipe_event_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush/stall/bubble handling.
// Optional saturating bubble counter built when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned REG_AW  = mips_pkg::REG_AW,
  parameter int unsigned ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bubble,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic [31:0]        bubble_count
);

  import mips_pkg::*;

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic [REG_AW-1:0] id_dst;
  logic              load_nop;

  // An invalid slot may carry garbage decode; strip its side-effect bits.
  assign id_ctrl = id_valid ? '{reg_write:  id_reg_write,
                                mem_read:   id_mem_read,
                                mem_write:  id_mem_write,
                                mem_to_reg: id_mem_to_reg} : CTRL_NOP;

  assign id_dst   = id_reg_dst ? id_rd : id_rt;
  assign load_nop = flush || (bubble && !ex_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alu_op  <= '0;
      ex_alu_src <= 1'b0;
      ex_ctrl    <= CTRL_NOP;
    end else if (load_nop) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_alu_op  <= '0;
      ex_alu_src <= 1'b0;
      ex_ctrl    <= CTRL_NOP;
    end else if (!ex_stall) begin
      ex_valid   <= id_valid;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_dst     <= id_dst;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_alu_op  <= id_alu_op;
      ex_alu_src <= id_alu_src;
      ex_ctrl    <= id_ctrl;
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
  // Only bubbles that actually displace an instruction are counted.
  logic bubble_hit;
  assign bubble_hit = bubble && !flush && !ex_stall;

  pipe_event_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_hit),
    .count (bubble_count)
  );
`else
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized bench for id_ex_pipe_reg against a rule-level model, plus literal pins.
module tb_id_ex_pipe_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 4;
`ifdef ID_EX_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bubble = 0, flush = 0, ex_stall = 0, id_valid = 0;
  logic [AW-1:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [DW-1:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [OW-1:0] id_alu_op = 0;
  logic id_alu_src = 0, id_reg_dst = 0, id_reg_write = 0;
  logic id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;

  logic          ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [AW-1:0] ex_rs, ex_rt, ex_dst;
  logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [OW-1:0] ex_alu_op;
  logic [31:0]   bubble_count;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .bubble(bubble), .flush(flush), .ex_stall(ex_stall),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .bubble_count(bubble_count)
  );

  // Reference model: what EX must hold after each edge, from the priority rules.
  logic          m_valid, m_src, m_rw, m_mr, m_mw, m_m2r;
  logic [AW-1:0] m_rs, m_rt, m_dst;
  logic [DW-1:0] m_rsd, m_rtd, m_imm;
  logic [OW-1:0] m_op;
  logic [31:0]   m_cnt;
  logic          preload = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} <= '0;
      {m_rs, m_rt, m_dst, m_rsd, m_rtd, m_imm, m_op} <= '0;
      m_cnt <= 32'd0;
    end else begin
      if (flush || (!ex_stall && bubble)) begin
        {m_valid, m_src, m_rw, m_mr, m_mw, m_m2r} <= '0;
        {m_rs, m_rt, m_dst, m_rsd, m_rtd, m_imm, m_op} <= '0;
      end else if (!ex_stall) begin
        m_valid <= id_valid;
        m_rs    <= id_rs;
        m_rt    <= id_rt;
        m_dst   <= id_reg_dst ? id_rd : id_rt;
        m_rsd   <= id_rs_data;
        m_rtd   <= id_rt_data;
        m_imm   <= id_imm;
        m_op    <= id_alu_op;
        m_src   <= id_alu_src;
        m_rw    <= id_valid && id_reg_write;
        m_mr    <= id_valid && id_mem_read;
        m_mw    <= id_valid && id_mem_write;
        m_m2r   <= id_valid && id_mem_to_reg;
      end
      if (preload) m_cnt <= 32'hFFFF_FFFE;
      else if (CNT_EN && bubble && !flush && !ex_stall && m_cnt != 32'hFFFF_FFFF)
        m_cnt <= m_cnt + 32'd1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b1;
  logic pin_en = 1'b0;
  logic pin_valid, pin_mr, pin_rw;
  logic [AW-1:0] pin_dst;
  logic [31:0]   pin_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: DUT vs model every cycle, plus literal pins when armed.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (chk_en) begin
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("ex_rs", 64'(ex_rs), 64'(m_rs));
        chk("ex_rt", 64'(ex_rt), 64'(m_rt));
        chk("ex_dst", 64'(ex_dst), 64'(m_dst));
        chk("ex_rs_data", 64'(ex_rs_data), 64'(m_rsd));
        chk("ex_rt_data", 64'(ex_rt_data), 64'(m_rtd));
        chk("ex_imm", 64'(ex_imm), 64'(m_imm));
        chk("ex_alu_op", 64'(ex_alu_op), 64'(m_op));
        chk("ex_alu_src", 64'(ex_alu_src), 64'(m_src));
        chk("ex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
            64'({m_rw, m_mr, m_mw, m_m2r}));
        chk("bubble_count", 64'(bubble_count), 64'(m_cnt));
      end
      if (pin_en) begin
        chk("pin_valid", 64'(ex_valid), 64'(pin_valid));
        chk("pin_dst", 64'(ex_dst), 64'(pin_dst));
        chk("pin_mem_read", 64'(ex_mem_read), 64'(pin_mr));
        chk("pin_reg_write", 64'(ex_reg_write), 64'(pin_rw));
        chk("pin_count", 64'(bubble_count), 64'(pin_cnt));
        chk("pin_model_dst", 64'(m_dst), 64'(pin_dst));
        chk("pin_model_count", 64'(m_cnt), 64'(pin_cnt));
      end
    end
  end

  task automatic rand_id();
    id_valid      = ($urandom_range(0, 7) != 0);
    id_rs         = AW'($urandom);
    id_rt         = AW'($urandom);
    id_rd         = AW'($urandom);
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    id_alu_op     = OW'($urandom);
    id_alu_src    = 1'($urandom);
    id_reg_dst    = 1'($urandom);
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
  endtask

  task automatic pin(input logic v, input logic [AW-1:0] d, input logic mr,
                     input logic rw, input logic [31:0] c);
    pin_valid = v; pin_dst = d; pin_mr = mr; pin_rw = rw; pin_cnt = c; pin_en = 1'b1;
  endtask

  // Arms pins just after the edge, clears them after the following negedge compare.
  task automatic edge_pin(input logic v, input logic [AW-1:0] d, input logic mr,
                          input logic rw, input logic [31:0] c);
    @(posedge clk); #1;
    pin(v, d, mr, rw, c);
    @(negedge clk); #2;
    pin_en = 1'b0;
  endtask

  logic [31:0] c1;

  initial begin
    c1 = CNT_EN ? 32'd1 : 32'd0;
    #12 rst_n = 1'b1;

    // Load something, then reset asynchronously mid-cycle.
    @(negedge clk); #2;
    rand_id(); id_valid = 1'b1; id_reg_write = 1'b1; id_rt = 5'd12; id_rd = 5'd13;
    @(posedge clk); #1;
    pin(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    #1 rst_n = 1'b0;
    #2 pin_en = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;

    // lw: dest is rt.
    rand_id(); id_valid = 1'b1; id_rt = 5'd5; id_rd = 5'd9; id_reg_dst = 1'b0;
    id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_write = 1'b0;
    edge_pin(1'b1, 5'd5, 1'b1, 1'b1, 32'd0);

    // Bubble over a valid add.
    rand_id(); id_valid = 1'b1; id_rd = 5'd3; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    bubble = 1'b1;
    edge_pin(1'b0, 5'd0, 1'b0, 1'b0, c1);
    bubble = 1'b0;

    // Load an add, then stall with bubble pending for 3 cycles.
    rand_id(); id_valid = 1'b1; id_rd = 5'd7; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    id_mem_read = 1'b0;
    edge_pin(1'b1, 5'd7, 1'b0, 1'b1, c1);
    for (int i = 0; i < 3; i++) begin
      rand_id(); ex_stall = 1'b1; bubble = 1'b1;
      edge_pin(1'b1, 5'd7, 1'b0, 1'b1, c1);
    end

    // Flush wins over stall and bubble.
    rand_id(); flush = 1'b1;
    edge_pin(1'b0, 5'd0, 1'b0, 1'b0, c1);
    flush = 1'b0; ex_stall = 1'b0; bubble = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #2;
      rand_id();
      bubble   = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 6) == 0);
      if (i == 1500) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturation: preload near the top, then three countable bubbles.
    @(negedge clk); #2;
    bubble = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    chk_en = 1'b0; preload = 1'b1;
    force dut.u_bubble_cnt.count = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.u_bubble_cnt.count;
    preload = 1'b0; chk_en = 1'b1;
    @(negedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      rand_id(); bubble = 1'b1;
      edge_pin(1'b0, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    end
    bubble = 1'b0;
`endif

    @(negedge clk); #2;
    @(negedge clk); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
